// File: rtl/dca_matrix_lsu_share_arbiter.sv
// Two-requester share arbiter for one matrix LSU port: round-robin whole-instruction
// grants held until execute_finish, with load/store row streams routed only to the owner.
module dca_matrix_lsu_share_arbiter #(
  parameter int BW_INST = 256,
  parameter int BW_ROW  = 256
) (
  input  logic               clk,
  input  logic               rstnn,

  input  logic               r0_sinst_wvalid,
  input  logic [BW_INST-1:0] r0_sinst_wdata,
  output logic               r0_sinst_wready,
  output logic               r0_sinst_decode_finish,
  output logic               r0_sinst_execute_finish,
  output logic               r0_sinst_busy,
  output logic               r0_sload_tensor_row_wvalid,
  output logic               r0_sload_tensor_row_wlast,
  output logic [BW_ROW-1:0]  r0_sload_tensor_row_wdata,
  input  logic               r0_sload_tensor_row_wready,
  output logic               r0_sstore_tensor_row_rvalid,
  output logic               r0_sstore_tensor_row_rlast,
  input  logic               r0_sstore_tensor_row_rready,
  input  logic [BW_ROW-1:0]  r0_sstore_tensor_row_rdata,

  input  logic               r1_sinst_wvalid,
  input  logic [BW_INST-1:0] r1_sinst_wdata,
  output logic               r1_sinst_wready,
  output logic               r1_sinst_decode_finish,
  output logic               r1_sinst_execute_finish,
  output logic               r1_sinst_busy,
  output logic               r1_sload_tensor_row_wvalid,
  output logic               r1_sload_tensor_row_wlast,
  output logic [BW_ROW-1:0]  r1_sload_tensor_row_wdata,
  input  logic               r1_sload_tensor_row_wready,
  output logic               r1_sstore_tensor_row_rvalid,
  output logic               r1_sstore_tensor_row_rlast,
  input  logic               r1_sstore_tensor_row_rready,
  input  logic [BW_ROW-1:0]  r1_sstore_tensor_row_rdata,

  output logic               m_sinst_wvalid,
  output logic [BW_INST-1:0] m_sinst_wdata,
  input  logic               m_sinst_wready,
  input  logic               m_sinst_decode_finish,
  input  logic               m_sinst_execute_finish,
  input  logic               m_sinst_busy,
  input  logic               m_sload_tensor_row_wvalid,
  input  logic               m_sload_tensor_row_wlast,
  input  logic [BW_ROW-1:0]  m_sload_tensor_row_wdata,
  output logic               m_sload_tensor_row_wready,
  input  logic               m_sstore_tensor_row_rvalid,
  input  logic               m_sstore_tensor_row_rlast,
  output logic               m_sstore_tensor_row_rready,
  output logic [BW_ROW-1:0]  m_sstore_tensor_row_rdata,

  output logic               grant_owner,
  output logic               grant_active
);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  logic               own_wvalid;
  logic [BW_INST-1:0] own_wdata;
  logic               own_load_wready;
  logic               own_store_rready;
  logic [BW_ROW-1:0]  own_store_rdata;

  assign own_wvalid       = owner_q ? r1_sinst_wvalid : r0_sinst_wvalid;
  assign own_wdata        = owner_q ? r1_sinst_wdata : r0_sinst_wdata;
  assign own_load_wready  = owner_q ? r1_sload_tensor_row_wready : r0_sload_tensor_row_wready;
  assign own_store_rready = owner_q ? r1_sstore_tensor_row_rready : r0_sstore_tensor_row_rready;
  assign own_store_rdata  = owner_q ? r1_sstore_tensor_row_rdata : r0_sstore_tensor_row_rdata;

  assign grant_owner  = owner_q;
  assign grant_active = (state_q != IDLE);

  // last_grant resets to 1 so r0 wins the first tie
  always_ff @(posedge clk or posedge rstnn) begin
    if (rstnn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (r0_sinst_wvalid && r1_sinst_wvalid) begin
          owner_d = ~last_grant_q;
          state_d = ISSUE;
        end else if (r0_sinst_wvalid) begin
          owner_d = 1'b0;
          state_d = ISSUE;
        end else if (r1_sinst_wvalid) begin
          owner_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // an owner withdrawing its request forfeits without advancing round-robin
        if (!own_wvalid) begin
          state_d = IDLE;
        end else if (m_sinst_wready) begin
          last_grant_d = owner_q;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (m_sinst_execute_finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_sinst_wvalid              = 1'b0;
    m_sinst_wdata               = '0;
    m_sload_tensor_row_wready   = 1'b0;
    m_sstore_tensor_row_rready  = 1'b0;
    m_sstore_tensor_row_rdata   = '0;
    r0_sinst_wready             = 1'b0;
    r0_sinst_decode_finish      = 1'b0;
    r0_sinst_execute_finish     = 1'b0;
    r0_sload_tensor_row_wvalid  = 1'b0;
    r0_sload_tensor_row_wlast   = 1'b0;
    r0_sload_tensor_row_wdata   = '0;
    r0_sstore_tensor_row_rvalid = 1'b0;
    r0_sstore_tensor_row_rlast  = 1'b0;
    r1_sinst_wready             = 1'b0;
    r1_sinst_decode_finish      = 1'b0;
    r1_sinst_execute_finish     = 1'b0;
    r1_sload_tensor_row_wvalid  = 1'b0;
    r1_sload_tensor_row_wlast   = 1'b0;
    r1_sload_tensor_row_wdata   = '0;
    r1_sstore_tensor_row_rvalid = 1'b0;
    r1_sstore_tensor_row_rlast  = 1'b0;
    r0_sinst_busy               = m_sinst_busy;
    r1_sinst_busy               = m_sinst_busy;

    case (state_q)
      ISSUE: begin
        m_sinst_wvalid = own_wvalid;
        m_sinst_wdata  = own_wdata;
        if (owner_q) r1_sinst_wready = m_sinst_wready;
        else         r0_sinst_wready = m_sinst_wready;
      end
      EXEC: begin
        m_sload_tensor_row_wready  = own_load_wready;
        m_sstore_tensor_row_rready = own_store_rready;
        m_sstore_tensor_row_rdata  = own_store_rdata;
        if (owner_q) begin
          r1_sinst_decode_finish      = m_sinst_decode_finish;
          r1_sinst_execute_finish     = m_sinst_execute_finish;
          r1_sload_tensor_row_wvalid  = m_sload_tensor_row_wvalid;
          r1_sload_tensor_row_wlast   = m_sload_tensor_row_wlast;
          r1_sload_tensor_row_wdata   = m_sload_tensor_row_wdata;
          r1_sstore_tensor_row_rvalid = m_sstore_tensor_row_rvalid;
          r1_sstore_tensor_row_rlast  = m_sstore_tensor_row_rlast;
        end else begin
          r0_sinst_decode_finish      = m_sinst_decode_finish;
          r0_sinst_execute_finish     = m_sinst_execute_finish;
          r0_sload_tensor_row_wvalid  = m_sload_tensor_row_wvalid;
          r0_sload_tensor_row_wlast   = m_sload_tensor_row_wlast;
          r0_sload_tensor_row_wdata   = m_sload_tensor_row_wdata;
          r0_sstore_tensor_row_rvalid = m_sstore_tensor_row_rvalid;
          r0_sstore_tensor_row_rlast  = m_sstore_tensor_row_rlast;
        end
      end
      default: ;
    endcase

    // the non-owner must see the shared LSU as occupied for the whole grant
    if (state_q != IDLE) begin
      if (owner_q) r0_sinst_busy = 1'b1;
      else         r1_sinst_busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_dca_matrix_lsu_share_arbiter.sv
// Scoreboard bench for the two-requester matrix LSU share arbiter.
module tb_dca_matrix_lsu_share_arbiter;
  localparam int BW = 256;

  typedef struct packed {
    logic          tag;
    logic [BW-1:0] data;
  } exp_t;

  logic clk, rstnn;
  logic r0_sinst_wvalid, r0_sinst_wready, r0_sinst_decode_finish, r0_sinst_execute_finish, r0_sinst_busy;
  logic [BW-1:0] r0_sinst_wdata;
  logic r0_sload_tensor_row_wvalid, r0_sload_tensor_row_wlast, r0_sload_tensor_row_wready;
  logic [BW-1:0] r0_sload_tensor_row_wdata;
  logic r0_sstore_tensor_row_rvalid, r0_sstore_tensor_row_rlast, r0_sstore_tensor_row_rready;
  logic [BW-1:0] r0_sstore_tensor_row_rdata;
  logic r1_sinst_wvalid, r1_sinst_wready, r1_sinst_decode_finish, r1_sinst_execute_finish, r1_sinst_busy;
  logic [BW-1:0] r1_sinst_wdata;
  logic r1_sload_tensor_row_wvalid, r1_sload_tensor_row_wlast, r1_sload_tensor_row_wready;
  logic [BW-1:0] r1_sload_tensor_row_wdata;
  logic r1_sstore_tensor_row_rvalid, r1_sstore_tensor_row_rlast, r1_sstore_tensor_row_rready;
  logic [BW-1:0] r1_sstore_tensor_row_rdata;
  logic m_sinst_wvalid, m_sinst_wready, m_sinst_decode_finish, m_sinst_execute_finish, m_sinst_busy;
  logic [BW-1:0] m_sinst_wdata;
  logic m_sload_tensor_row_wvalid, m_sload_tensor_row_wlast, m_sload_tensor_row_wready;
  logic [BW-1:0] m_sload_tensor_row_wdata;
  logic m_sstore_tensor_row_rvalid, m_sstore_tensor_row_rlast, m_sstore_tensor_row_rready;
  logic [BW-1:0] m_sstore_tensor_row_rdata;
  logic grant_owner, grant_active;

  int checks = 0;
  int errors = 0;
  exp_t inst_q[$];
  exp_t load_q[$];
  exp_t store_q[$];

  dca_matrix_lsu_share_arbiter #(.BW_INST(BW), .BW_ROW(BW)) dut (
    .clk(clk), .rstnn(rstnn),
    .r0_sinst_wvalid(r0_sinst_wvalid), .r0_sinst_wdata(r0_sinst_wdata), .r0_sinst_wready(r0_sinst_wready),
    .r0_sinst_decode_finish(r0_sinst_decode_finish), .r0_sinst_execute_finish(r0_sinst_execute_finish),
    .r0_sinst_busy(r0_sinst_busy),
    .r0_sload_tensor_row_wvalid(r0_sload_tensor_row_wvalid), .r0_sload_tensor_row_wlast(r0_sload_tensor_row_wlast),
    .r0_sload_tensor_row_wdata(r0_sload_tensor_row_wdata), .r0_sload_tensor_row_wready(r0_sload_tensor_row_wready),
    .r0_sstore_tensor_row_rvalid(r0_sstore_tensor_row_rvalid), .r0_sstore_tensor_row_rlast(r0_sstore_tensor_row_rlast),
    .r0_sstore_tensor_row_rready(r0_sstore_tensor_row_rready), .r0_sstore_tensor_row_rdata(r0_sstore_tensor_row_rdata),
    .r1_sinst_wvalid(r1_sinst_wvalid), .r1_sinst_wdata(r1_sinst_wdata), .r1_sinst_wready(r1_sinst_wready),
    .r1_sinst_decode_finish(r1_sinst_decode_finish), .r1_sinst_execute_finish(r1_sinst_execute_finish),
    .r1_sinst_busy(r1_sinst_busy),
    .r1_sload_tensor_row_wvalid(r1_sload_tensor_row_wvalid), .r1_sload_tensor_row_wlast(r1_sload_tensor_row_wlast),
    .r1_sload_tensor_row_wdata(r1_sload_tensor_row_wdata), .r1_sload_tensor_row_wready(r1_sload_tensor_row_wready),
    .r1_sstore_tensor_row_rvalid(r1_sstore_tensor_row_rvalid), .r1_sstore_tensor_row_rlast(r1_sstore_tensor_row_rlast),
    .r1_sstore_tensor_row_rready(r1_sstore_tensor_row_rready), .r1_sstore_tensor_row_rdata(r1_sstore_tensor_row_rdata),
    .m_sinst_wvalid(m_sinst_wvalid), .m_sinst_wdata(m_sinst_wdata), .m_sinst_wready(m_sinst_wready),
    .m_sinst_decode_finish(m_sinst_decode_finish), .m_sinst_execute_finish(m_sinst_execute_finish),
    .m_sinst_busy(m_sinst_busy),
    .m_sload_tensor_row_wvalid(m_sload_tensor_row_wvalid), .m_sload_tensor_row_wlast(m_sload_tensor_row_wlast),
    .m_sload_tensor_row_wdata(m_sload_tensor_row_wdata), .m_sload_tensor_row_wready(m_sload_tensor_row_wready),
    .m_sstore_tensor_row_rvalid(m_sstore_tensor_row_rvalid), .m_sstore_tensor_row_rlast(m_sstore_tensor_row_rlast),
    .m_sstore_tensor_row_rready(m_sstore_tensor_row_rready), .m_sstore_tensor_row_rdata(m_sstore_tensor_row_rdata),
    .grant_owner(grant_owner), .grant_active(grant_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_sinst_wvalid && m_sinst_wready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    exp_t e;
    bit ok;
    int beat;
    logic [4:0] pat;
    logic [BW-1:0] st_data [3];

    rstnn = 1'b1;
    {r0_sinst_wvalid, r1_sinst_wvalid, r0_sload_tensor_row_wready, r1_sload_tensor_row_wready} = '0;
    {r0_sstore_tensor_row_rready, r1_sstore_tensor_row_rready} = '0;
    r0_sinst_wdata = '0; r1_sinst_wdata = '0;
    r0_sstore_tensor_row_rdata = '0; r1_sstore_tensor_row_rdata = '0;
    {m_sinst_wready, m_sinst_decode_finish, m_sinst_execute_finish} = '0;
    {m_sload_tensor_row_wvalid, m_sload_tensor_row_wlast, m_sstore_tensor_row_rvalid, m_sstore_tensor_row_rlast} = '0;
    m_sload_tensor_row_wdata = '0;
    m_sinst_busy = 1'b1;

    // monitor: compares every handshake the DUT presents against the scoreboards
    fork
      forever begin
        @(negedge clk);
        if (m_sinst_wvalid && m_sinst_wready) begin
          if (inst_q.size() == 0) chk("inst_unexpected", m_sinst_wdata, '1);
          else begin
            e = inst_q.pop_front();
            chk("inst_data", m_sinst_wdata, e.data);
            chk("inst_owner", {255'd0, grant_owner}, {255'd0, e.tag});
          end
        end
        if (r1_sload_tensor_row_wvalid && r1_sload_tensor_row_wready) begin
          if (load_q.size() == 0) chk("load_unexpected", r1_sload_tensor_row_wdata, '1);
          else begin
            e = load_q.pop_front();
            chk("load_data", r1_sload_tensor_row_wdata, e.data);
            chk("load_last", {255'd0, r1_sload_tensor_row_wlast}, {255'd0, e.tag});
          end
        end
        if (m_sstore_tensor_row_rvalid && m_sstore_tensor_row_rready) begin
          if (store_q.size() == 0) chk("store_unexpected", m_sstore_tensor_row_rdata, '1);
          else begin
            e = store_q.pop_front();
            chk("store_data", m_sstore_tensor_row_rdata, e.data);
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active", grant_active, 0);
    chk("rst_owner", grant_owner, 0);
    chk("rst_m_wvalid", m_sinst_wvalid, 0);
    chk("rst_r0_busy", r0_sinst_busy, 1);
    chk("rst_r1_busy", r1_sinst_busy, 1);
    m_sinst_busy = 1'b0;
    rstnn = 1'b0;
    step();

    // tie after reset: r0 first, r1 two cycles after execute_finish
    m_sinst_wready = 1'b1;
    inst_q.push_back('{1'b0, 256'h0A});
    inst_q.push_back('{1'b1, 256'h1B});
    r0_sinst_wvalid = 1'b1; r0_sinst_wdata = 256'h0A;
    r1_sinst_wvalid = 1'b1; r1_sinst_wdata = 256'h1B;
    step();
    chk("tie_owner0", grant_owner, 0);
    chk("tie_r0_wready", r0_sinst_wready, 1);
    chk("tie_r1_wready", r1_sinst_wready, 0);
    chk("tie_r0_busy", r0_sinst_busy, 0);
    chk("tie_r1_busy", r1_sinst_busy, 1);
    step();
    r0_sinst_wvalid = 1'b0;
    m_sinst_decode_finish = 1'b1; m_sinst_execute_finish = 1'b1;
    #1;
    chk("exec_m_wvalid", m_sinst_wvalid, 0);
    chk("fin_r0_decode", r0_sinst_decode_finish, 1);
    chk("fin_r0_exec", r0_sinst_execute_finish, 1);
    chk("fin_r1_exec", r1_sinst_execute_finish, 0);
    step();
    m_sinst_decode_finish = 1'b0; m_sinst_execute_finish = 1'b0;
    chk("fin_idle", grant_active, 0);
    chk("fin_idle_wvalid", m_sinst_wvalid, 0);
    step();
    chk("tie_r1_wvalid_t2", m_sinst_wvalid, 1);
    chk("tie_owner1", grant_owner, 1);
    step();
    r1_sinst_wvalid = 1'b0;

    // load stream to r1 with wready 1,0,1,1,1
    pat = 5'b11101;
    for (int i = 0; i < 4; i++) load_q.push_back('{(i == 3), 256'hD1 + i});
    beat = 0;
    for (int k = 0; k < 5; k++) begin
      r1_sload_tensor_row_wready = pat[k];
      m_sload_tensor_row_wvalid = (beat < 4);
      m_sload_tensor_row_wdata = 256'hD1 + beat;
      m_sload_tensor_row_wlast = (beat == 3);
      #1;
      chk("load_r0_wvalid", r0_sload_tensor_row_wvalid, 0);
      chk("load_r0_wdata", r0_sload_tensor_row_wdata, 0);
      @(posedge clk);
      if (m_sload_tensor_row_wvalid && pat[k]) beat++;
      #1;
    end
    m_sload_tensor_row_wvalid = 1'b0; m_sload_tensor_row_wlast = 1'b0;
    r1_sload_tensor_row_wready = 1'b0;
    chk("load_left", load_q.size(), 0);
    m_sinst_execute_finish = 1'b1;
    step();
    m_sinst_execute_finish = 1'b0;

    // single request 0xA5 then store stream from r0
    inst_q.push_back('{1'b0, 256'hA5});
    r0_sinst_wvalid = 1'b1; r0_sinst_wdata = 256'hA5;
    step();
    chk("single_wvalid", m_sinst_wvalid, 1);
    chk("single_wdata", m_sinst_wdata, 256'hA5);
    chk("single_wready", r0_sinst_wready, 1);
    chk("single_owner", grant_owner, 0);
    chk("single_active", grant_active, 1);
    step();
    r0_sinst_wvalid = 1'b0;
    chk("single_wready_pulse", r0_sinst_wready, 0);
    st_data[0] = 256'h11; st_data[1] = 256'h22; st_data[2] = 256'h33;
    for (int i = 0; i < 3; i++) store_q.push_back('{1'b0, st_data[i]});
    for (int i = 0; i < 3; i++) begin
      m_sstore_tensor_row_rvalid = 1'b1; m_sstore_tensor_row_rlast = (i == 2);
      r0_sstore_tensor_row_rready = 1'b1; r0_sstore_tensor_row_rdata = st_data[i];
      #1;
      chk("store_r0_rvalid", r0_sstore_tensor_row_rvalid, 1);
      chk("store_r1_rvalid", r1_sstore_tensor_row_rvalid, 0);
      step();
    end
    m_sstore_tensor_row_rvalid = 1'b0; m_sstore_tensor_row_rlast = 1'b0;
    r0_sstore_tensor_row_rready = 1'b0;
    chk("store_left", store_q.size(), 0);
    m_sinst_execute_finish = 1'b1;
    step();
    m_sinst_execute_finish = 1'b0;

    // stray finish pulses in IDLE are dropped
    m_sinst_execute_finish = 1'b1; m_sinst_decode_finish = 1'b1;
    #1;
    chk("stray_r0_exec", r0_sinst_execute_finish, 0);
    step();
    m_sinst_execute_finish = 1'b0; m_sinst_decode_finish = 1'b0;
    chk("stray_active", grant_active, 0);

    // abort: r0 withdraws in ISSUE, pending r1 is granted next
    m_sinst_wready = 1'b0;
    r0_sinst_wvalid = 1'b1; r0_sinst_wdata = 256'h55;
    step();
    chk("abort_owner0", grant_owner, 0);
    chk("abort_r0_wready", r0_sinst_wready, 0);
    r0_sinst_wvalid = 1'b0;
    r1_sinst_wvalid = 1'b1; r1_sinst_wdata = 256'h77;
    inst_q.push_back('{1'b1, 256'h77});
    step();
    chk("abort_idle", grant_active, 0);
    step();
    m_sinst_wready = 1'b1;
    #1;
    chk("abort_owner1", grant_owner, 1);
    chk("abort_wdata", m_sinst_wdata, 256'h77);
    step();
    r1_sinst_wvalid = 1'b0;
    m_sinst_execute_finish = 1'b1;
    step();
    m_sinst_execute_finish = 1'b0;

    // fairness: both request continuously for six instructions
    for (int i = 0; i < 3; i++) begin
      inst_q.push_back('{1'b0, 256'h100 + i});
      inst_q.push_back('{1'b1, 256'h200 + i});
    end
    r0_sinst_wvalid = 1'b1; r0_sinst_wdata = 256'h100;
    r1_sinst_wvalid = 1'b1; r1_sinst_wdata = 256'h200;
    for (int i = 0; i < 6; i++) begin
      wait_hs(ok);
      chk("fair_handshake", {255'd0, ok}, 1);
      if (!ok) break;
      step();
      if (grant_owner) r1_sinst_wdata = r1_sinst_wdata + 1;
      else             r0_sinst_wdata = r0_sinst_wdata + 1;
      m_sinst_execute_finish = 1'b1;
      step();
      m_sinst_execute_finish = 1'b0;
    end
    r0_sinst_wvalid = 1'b0; r1_sinst_wvalid = 1'b0;
    chk("fair_left", inst_q.size(), 0);

    // reset asserted mid-EXEC clears outputs immediately
    inst_q.push_back('{1'b0, 256'hEE});
    r0_sinst_wvalid = 1'b1; r0_sinst_wdata = 256'hEE;
    step();
    step();
    r0_sinst_wvalid = 1'b0;
    m_sload_tensor_row_wvalid = 1'b1; m_sload_tensor_row_wdata = 256'hF0;
    #1;
    chk("mid_r0_load_wvalid", r0_sload_tensor_row_wvalid, 1);
    rstnn = 1'b1;
    #1;
    chk("mid_rst_active", grant_active, 0);
    chk("mid_rst_load_wvalid", r0_sload_tensor_row_wvalid, 0);
    chk("mid_rst_load_wdata", r0_sload_tensor_row_wdata, 0);
    chk("mid_rst_owner", grant_owner, 0);
    m_sload_tensor_row_wvalid = 1'b0;
    step();
    rstnn = 1'b0;
    step();
    chk("end_active", grant_active, 0);
    chk("end_inst_left", inst_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
